mac_stream_engine: RTL and testbench

Parametrised, streaming successor to the single-lane MAC. It holds a reloadable coefficient bank of up to 2^ADDR_LINES taps and replays it automatically for every block of samples. Each block produces one rounded, saturated fixed-point dot product. Inputs and outputs use valid/ready handshakes, and results are buffered in an internal output FIFO with credit-based input throttling. It sits between the sample source and the non-linear approximation stages.

---
 rtl/mac_stream_engine.sv | 172 +++++++++++++++++
 tb/tb_mac_stream_engine.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_engine.sv
// Streaming MAC engine: a reloadable coefficient bank is replayed for every block of samples,
// producing one rounded, saturated dot product per block into a credit-protected output FIFO.
module mac_stream_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_LINES = 4,
    parameter int FRAC_BITS  = 16,
    parameter int OUT_DEPTH  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_LINES:0]          cfg_taps_i,
    input  logic                         coef_load_i,
    input  logic                         coef_valid_i,
    input  logic signed [DATA_WIDTH-1:0] coef_data_i,
    output logic                         coef_ready_o,
    input  logic                         sample_valid_i,
    input  logic signed [DATA_WIDTH-1:0] sample_data_i,
    output logic                         sample_ready_o,
    output logic                         result_valid_o,
    input  logic                         result_ready_i,
    output logic signed [DATA_WIDTH-1:0] result_data_o,
    output logic                         result_sat_o,
    output logic                         busy_o
);
    localparam int DEPTH  = 1 << ADDR_LINES;
    localparam int TW     = ADDR_LINES + 1;
    localparam int ACC_W  = 2 * DATA_WIDTH + ADDR_LINES;
    localparam int RW     = ACC_W + 1;
    localparam int CW     = $clog2(OUT_DEPTH + 1);
    localparam int PW     = $clog2(OUT_DEPTH);
    localparam int RND_SH = (FRAC_BITS > 0) ? FRAC_BITS - 1 : 0;

    localparam logic signed [RW-1:0] RND_C   = RW'(FRAC_BITS > 0) << RND_SH;
    localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    function automatic logic [TW-1:0] clamp_taps(input logic [TW-1:0] cfg);
        if (cfg == '0) return TW'(1);
        if (cfg > TW'(DEPTH)) return TW'(DEPTH);
        return cfg;
    endfunction

    // One guard bit above the accumulator keeps the rounding add from wrapping.
    function automatic logic signed [RW-1:0] round_acc(input logic signed [ACC_W-1:0] sum);
        logic signed [RW-1:0] ext;
        ext = RW'(sum);
        return (ext + RND_C) >>> FRAC_BITS;
    endfunction

    function automatic logic [DATA_WIDTH:0] sat_res(input logic signed [RW-1:0] v);
        if (v > SAT_MAX) return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        if (v < SAT_MIN) return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        return {1'b0, v[DATA_WIDTH-1:0]};
    endfunction

    state_t                         state_q, state_d;
    logic [TW-1:0]                  taps_q;
    logic [ADDR_LINES-1:0]          wr_ptr, rd_ptr;
    logic                           pending_q;
    logic signed [ACC_W-1:0]        acc_q, sum_c;
    logic                           vld_p1, last_p1;
    logic signed [2*DATA_WIDTH-1:0] prod_p1;
    logic signed [DATA_WIDTH-1:0]   coef_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0]   fifo_data [OUT_DEPTH];
    logic                           fifo_sat [OUT_DEPTH];
    logic [PW-1:0]                  fifo_wr, fifo_rd;
    logic [CW-1:0]                  fifo_count;
    logic [CW:0]                    credit;
    logic [DATA_WIDTH:0]            res_c;
    logic coef_fire, sample_fire, wr_last, rd_last, load_req, go_load, push, pop;

    assign coef_fire   = coef_ready_o && coef_valid_i;
    assign sample_fire = sample_ready_o && sample_valid_i;
    assign wr_last     = ({1'b0, wr_ptr} == taps_q - TW'(1));
    assign rd_last     = ({1'b0, rd_ptr} == taps_q - TW'(1));
    assign load_req    = coef_load_i && (state_q == IDLE || state_q == RUN);
    assign go_load     = (state_q == RUN) && pending_q && !vld_p1;
    assign push        = vld_p1 && last_p1;
    assign pop         = result_valid_o && result_ready_i;
    assign credit      = {1'b0, fifo_count} + (CW+1)'(push);
    assign sum_c       = acc_q + ACC_W'(prod_p1);
    assign res_c       = sat_res(round_acc(sum_c));

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (coef_load_i) state_d = LOAD;
            LOAD:    if (coef_fire && wr_last) state_d = RUN;
            RUN:     if (go_load) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coef_ready_o   = 1'b0;
        sample_ready_o = 1'b0;
        busy_o         = pending_q || vld_p1;
        case (state_q)
            LOAD: begin
                coef_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            RUN:     sample_ready_o = !pending_q && (credit < (CW+1)'(OUT_DEPTH));
            default: ;
        endcase
    end

    // Control: pointers, reload bookkeeping, accumulator and FIFO occupancy.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            taps_q     <= TW'(1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending_q  <= 1'b0;
            acc_q      <= '0;
            vld_p1     <= 1'b0;
            last_p1    <= 1'b0;
            fifo_wr    <= '0;
            fifo_rd    <= '0;
            fifo_count <= '0;
        end else begin
            if (load_req) taps_q <= clamp_taps(cfg_taps_i);

            if (go_load || state_q != RUN) pending_q <= 1'b0;
            else if (coef_load_i)          pending_q <= 1'b1;

            if (coef_fire) wr_ptr <= wr_last ? '0 : wr_ptr + 1'b1;

            if (go_load || (coef_fire && wr_last)) rd_ptr <= '0;
            else if (sample_fire)                  rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;

            if (go_load)     acc_q <= '0;
            else if (vld_p1) acc_q <= last_p1 ? '0 : sum_c;

            vld_p1  <= sample_fire;
            last_p1 <= sample_fire && rd_last;

            if (push) fifo_wr <= (fifo_wr == PW'(OUT_DEPTH - 1)) ? '0 : fifo_wr + 1'b1;
            if (pop)  fifo_rd <= (fifo_rd == PW'(OUT_DEPTH - 1)) ? '0 : fifo_rd + 1'b1;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Stage 0 -> 1: coefficient bank write and product register.
    always_ff @(posedge clk_i) begin
        if (coef_fire) coef_mem[wr_ptr] <= coef_data_i;
        if (sample_fire) prod_p1 <= (2*DATA_WIDTH)'(sample_data_i) * (2*DATA_WIDTH)'(coef_mem[rd_ptr]);
    end

    // Stage 1 -> 2: finished dot products enter the output FIFO.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_data[fifo_wr] <= res_c[DATA_WIDTH-1:0];
            fifo_sat[fifo_wr]  <= res_c[DATA_WIDTH];
        end
    end

    assign result_valid_o = (fifo_count != '0);
    assign result_data_o  = result_valid_o ? fifo_data[fifo_rd] : '0;
    assign result_sat_o   = result_valid_o ? fifo_sat[fifo_rd] : 1'b0;
endmodule

// File: tb/tb_mac_stream_engine.sv
// Scoreboarded bench for mac_stream_engine: a reference model queues expected block results
// as samples are accepted; a monitor pops and compares them as the FIFO drains.
module tb_mac_stream_engine;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  cfg_taps_i = '0;
    logic        coef_load_i = 1'b0;
    logic        coef_valid_i = 1'b0;
    logic [31:0] coef_data_i = '0;
    logic        coef_ready_o;
    logic        sample_valid_i = 1'b0;
    logic [31:0] sample_data_i = '0;
    logic        sample_ready_o;
    logic        result_valid_o;
    logic        result_ready_i = 1'b1;
    logic [31:0] result_data_o;
    logic        result_sat_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]        tb_coef [16];
    int                 tb_taps = 1;
    int                 tb_idx  = 0;
    logic signed [79:0] tb_acc  = '0;
    logic [32:0]        sb [$];

    mac_stream_engine #(.DATA_WIDTH(32), .ADDR_LINES(4), .FRAC_BITS(16), .OUT_DEPTH(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .cfg_taps_i(cfg_taps_i), .coef_load_i(coef_load_i),
        .coef_valid_i(coef_valid_i), .coef_data_i(coef_data_i), .coef_ready_o(coef_ready_o),
        .sample_valid_i(sample_valid_i), .sample_data_i(sample_data_i),
        .sample_ready_o(sample_ready_o), .result_valid_o(result_valid_o),
        .result_ready_i(result_ready_i), .result_data_o(result_data_o),
        .result_sat_o(result_sat_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [32:0] exp_result(input logic signed [79:0] a);
        logic signed [79:0] r;
        r = (a + 80'sd32768) >>> 16;
        if (r > 80'sd2147483647) return {1'b1, 32'h7FFFFFFF};
        if (r < -80'sd2147483648) return {1'b1, 32'h80000000};
        return {1'b0, r[31:0]};
    endfunction

    function automatic int clamp_model(input int cfg);
        if (cfg == 0) return 1;
        if (cfg > 16) return 16;
        return cfg;
    endfunction

    task automatic model_accept(input logic [31:0] d);
        logic signed [31:0] sd, sc;
        logic signed [63:0] p;
        sd = d;
        sc = tb_coef[tb_idx];
        p  = 64'(sd) * 64'(sc);
        tb_acc = tb_acc + 80'(p);
        if (tb_idx == tb_taps - 1) begin
            sb.push_back(exp_result(tb_acc));
            tb_acc = '0;
            tb_idx = 0;
        end else begin
            tb_idx++;
        end
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && result_valid_o && result_ready_i) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got %h sat %b, none expected", result_data_o, result_sat_o);
            end else begin
                logic [32:0] e;
                e = sb.pop_front();
                if ({result_sat_o, result_data_o} !== e) begin
                    n_fail++;
                    $display("FAIL result: got sat %b data %h, expected sat %b data %h",
                             result_sat_o, result_data_o, e[32], e[31:0]);
                end
            end
        end
    end

    task automatic start_load(input int cfg);
        coef_load_i = 1'b1;
        cfg_taps_i  = 5'(cfg);
        @(posedge clk_i); #1;
        coef_load_i = 1'b0;
        tb_taps = clamp_model(cfg);
        tb_idx  = 0;
        tb_acc  = '0;
    endtask

    task automatic feed_coefs(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            bit ok;
            ok = 0;
            coef_valid_i = 1'b1;
            coef_data_i  = tb_coef[i];
            for (int c = 0; c < 40 && !ok; c++) begin
                @(negedge clk_i);
                if (coef_ready_o) ok = 1;
                @(posedge clk_i); #1;
            end
            if (!ok) begin
                n_checks++; n_fail++;
                $display("FAIL coef_timeout: coef %0d not accepted, required accept", i);
            end
        end
        coef_valid_i = 1'b0;
    endtask

    task automatic send_sample(input logic [31:0] d);
        bit ok;
        ok = 0;
        sample_valid_i = 1'b1;
        sample_data_i  = d;
        for (int c = 0; c < 40 && !ok; c++) begin
            @(negedge clk_i);
            if (sample_ready_o) ok = 1;
            @(posedge clk_i); #1;
        end
        if (ok) model_accept(d);
        else begin
            n_checks++; n_fail++;
            $display("FAIL sample_timeout: sample %h not accepted, required accept", d);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 60 && sb.size() != 0; c++) begin
            @(posedge clk_i); #1;
        end
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1 rst_i = 1'b0;
        @(negedge clk_i);
        n_checks++; if (coef_ready_o !== 1'b0)   begin n_fail++; $display("FAIL rst_coef_ready: got %b required 0", coef_ready_o); end
        n_checks++; if (sample_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_sample_ready: got %b required 0", sample_ready_o); end
        n_checks++; if (result_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_result_valid: got %b required 0", result_valid_o); end
        n_checks++; if (result_data_o !== 32'h0) begin n_fail++; $display("FAIL rst_result_data: got %h required 0", result_data_o); end
        n_checks++; if (result_sat_o !== 1'b0)   begin n_fail++; $display("FAIL rst_result_sat: got %b required 0", result_sat_o); end
        n_checks++; if (busy_o !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b required 0", busy_o); end
        @(posedge clk_i); #1;
    endtask

    task automatic test_basic();
        tb_coef[0] = 32'h00010000; tb_coef[1] = 32'h00020000; tb_coef[2] = 32'hFFFF8000;
        start_load(3);
        feed_coefs(0, 3);
        for (int rep = 0; rep < 2; rep++) begin
            send_sample(32'h00010000);
            send_sample(32'h00010000);
            send_sample(32'h00020000);
            sample_valid_i = 1'b0;
            n_checks++; if (result_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b required 0", result_valid_o); end
            @(posedge clk_i); #1;
            n_checks++; if (result_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency: got %b required 1", result_valid_o); end
            n_checks++; if (result_data_o !== 32'h00020000) begin n_fail++; $display("FAIL basic_data: got %h required 00020000", result_data_o); end
            n_checks++; if (result_sat_o !== 1'b0) begin n_fail++; $display("FAIL basic_sat: got %b required 0", result_sat_o); end
            wait_drain();
        end
    endtask

    task automatic test_saturation();
        logic [31:0] s [2];
        logic [31:0] e [2];
        s[0] = 32'h7FFFFFFF; s[1] = 32'h80000001;
        e[0] = 32'h7FFFFFFF; e[1] = 32'h80000000;
        tb_coef[0] = 32'h7FFFFFFF; tb_coef[1] = 32'h7FFFFFFF;
        start_load(2);
        feed_coefs(0, 2);
        for (int k = 0; k < 2; k++) begin
            send_sample(s[k]);
            send_sample(s[k]);
            sample_valid_i = 1'b0;
            @(posedge clk_i); #1;
            n_checks++; if (result_data_o !== e[k]) begin n_fail++; $display("FAIL sat_data%0d: got %h required %h", k, result_data_o, e[k]); end
            n_checks++; if (result_sat_o !== 1'b1) begin n_fail++; $display("FAIL sat_flag%0d: got %b required 1", k, result_sat_o); end
            wait_drain();
        end
    endtask

    task automatic test_backpressure();
        int accepted;
        int stalls;
        tb_coef[0] = 32'h00010000;
        start_load(1);
        feed_coefs(0, 1);
        result_ready_i = 1'b0;
        accepted = 0;
        sample_valid_i = 1'b1;
        sample_data_i  = 32'h00010000;
        for (int c = 0; c < 12; c++) begin
            bit rdy;
            @(negedge clk_i);
            rdy = sample_ready_o;
            @(posedge clk_i); #1;
            if (rdy) begin
                model_accept(sample_data_i);
                accepted++;
                sample_data_i = 32'(accepted + 1) << 16;
            end
        end
        n_checks++; if (accepted != 4) begin n_fail++; $display("FAIL bp_accepted: got %0d required 4", accepted); end
        n_checks++; if (sample_ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low: got %b required 0", sample_ready_o); end
        n_checks++; if (result_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_fifo_full_valid: got %b required 1", result_valid_o); end
        sample_valid_i = 1'b0;
        result_ready_i = 1'b1;
        wait_drain();
        stalls = 0;
        sample_valid_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bit rdy;
            sample_data_i = 32'(c + 5) << 16;
            @(negedge clk_i);
            rdy = sample_ready_o;
            @(posedge clk_i); #1;
            if (rdy) model_accept(sample_data_i);
            else stalls++;
        end
        sample_valid_i = 1'b0;
        n_checks++; if (stalls != 0) begin n_fail++; $display("FAIL bp_stream_stalls: got %0d required 0", stalls); end
        wait_drain();
    endtask

    task automatic test_midblock_reload();
        bit got_rdy;
        bit seen_load;
        for (int i = 0; i < 4; i++) tb_coef[i] = 32'h00010000;
        start_load(4);
        feed_coefs(0, 4);
        send_sample(32'h00010000);
        send_sample(32'h00020000);
        sample_valid_i = 1'b0;
        start_load(2);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL reload_busy: got %b required 1", busy_o); end
        sample_valid_i = 1'b1;
        sample_data_i  = 32'h00030000;
        got_rdy = 0;
        seen_load = 0;
        for (int c = 0; c < 20 && !seen_load; c++) begin
            @(negedge clk_i);
            if (sample_ready_o) got_rdy = 1;
            if (coef_ready_o) seen_load = 1;
            @(posedge clk_i); #1;
        end
        sample_valid_i = 1'b0;
        n_checks++; if (got_rdy !== 1'b0) begin n_fail++; $display("FAIL reload_no_accept: got ready %b required 0", got_rdy); end
        n_checks++; if (seen_load !== 1'b1) begin n_fail++; $display("FAIL reload_coef_ready: got %b required 1", seen_load); end
        tb_coef[0] = 32'h00030000; tb_coef[1] = 32'hFFFE0000;
        feed_coefs(0, 2);
        send_sample(32'h00010000);
        send_sample(32'h00010000);
        sample_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (result_data_o !== 32'h00010000) begin n_fail++; $display("FAIL reload_data: got %h required 00010000", result_data_o); end
        wait_drain();
    endtask

    task automatic test_clamp();
        tb_coef[0] = 32'h00020000;
        start_load(0);
        feed_coefs(0, 1);
        n_checks++; if (coef_ready_o !== 1'b0) begin n_fail++; $display("FAIL clamp0_load_done: got %b required 0", coef_ready_o); end
        send_sample(32'h00018000);
        sample_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (result_data_o !== 32'h00030000) begin n_fail++; $display("FAIL clamp0_data: got %h required 00030000", result_data_o); end
        wait_drain();

        for (int i = 0; i < 16; i++) tb_coef[i] = 32'((i - 7) * 4096);
        start_load(20);
        feed_coefs(0, 15);
        n_checks++; if (coef_ready_o !== 1'b1) begin n_fail++; $display("FAIL clamp20_after15: got %b required 1", coef_ready_o); end
        feed_coefs(15, 1);
        n_checks++; if (coef_ready_o !== 1'b0) begin n_fail++; $display("FAIL clamp20_after16: got %b required 0", coef_ready_o); end
        n_checks++; if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL clamp20_run: got %b required 1", sample_ready_o); end
        for (int i = 0; i < 15; i++) send_sample(32'((i + 1) * 32'h3000));
        sample_valid_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        n_checks++; if (result_valid_o !== 1'b0) begin n_fail++; $display("FAIL clamp20_early: got %b required 0", result_valid_o); end
        send_sample(32'(16 * 32'h3000));
        sample_valid_i = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset_midload();
        bit got_rdy;
        tb_coef[0] = 32'h00010000; tb_coef[1] = 32'h00010000;
        tb_coef[2] = 32'h00010000; tb_coef[3] = 32'h00010000;
        start_load(4);
        feed_coefs(0, 2);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        sb.delete();
        tb_acc = '0;
        tb_idx = 0;
        @(negedge clk_i);
        n_checks++;
        if ({coef_ready_o, sample_ready_o, result_valid_o, result_sat_o, busy_o, result_data_o} !== 37'h0) begin
            n_fail++;
            $display("FAIL midload_reset_outputs: got %b%b%b%b%b %h required all 0",
                     coef_ready_o, sample_ready_o, result_valid_o, result_sat_o, busy_o, result_data_o);
        end
        @(posedge clk_i); #1;
        sample_valid_i = 1'b1;
        sample_data_i  = 32'h00010000;
        got_rdy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_i);
            if (sample_ready_o) got_rdy = 1;
            @(posedge clk_i); #1;
        end
        start_load(2);
        feed_coefs(0, 1);
        @(negedge clk_i);
        if (sample_ready_o) got_rdy = 1;
        @(posedge clk_i); #1;
        sample_valid_i = 1'b0;
        n_checks++; if (got_rdy !== 1'b0) begin n_fail++; $display("FAIL midload_ready_held: got %b required 0", got_rdy); end
        feed_coefs(1, 1);
        n_checks++; if (sample_ready_o !== 1'b1) begin n_fail++; $display("FAIL midload_reload_run: got %b required 1", sample_ready_o); end
        send_sample(32'h00005000);
        send_sample(32'h00007000);
        sample_valid_i = 1'b0;
        @(posedge clk_i); #1;
        n_checks++; if (result_data_o !== 32'h0000C000) begin n_fail++; $display("FAIL midload_data: got %h required 0000C000", result_data_o); end
        wait_drain();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_backpressure();
        test_midblock_reload();
        test_clamp();
        test_reset_midload();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
